// File: rtl/frame_stream_arbiter_if.sv
// One AXI4-Stream video link (pixel data, start-of-frame, end-of-line, handshake).
// The driving side uses the master modport; the receiving side uses the slave modport.
interface frame_stream_arbiter_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tuser;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/frame_stream_arbiter.sv
// Two-source AXI4-Stream video arbiter that hands the output over only on frame boundaries.
// Define FSA_WATCHDOG_EN to add a stall watchdog that revokes a grant after WDOG_CYCLES idle cycles.
module frame_stream_arbiter #(
  parameter int TDATA_WIDTH     = 32,
  parameter int LINES_PER_FRAME = 1080,
  parameter int WDOG_CYCLES     = 4096
) (
  input  logic                   aclk,
  input  logic                   areset,
  frame_stream_arbiter_if.slave  s0,
  frame_stream_arbiter_if.slave  s1,
  frame_stream_arbiter_if.master m,
  output logic                   fsync,
  output logic [1:0]             grant,
  output logic                   frame_done,
  output logic                   wdog_err
);
  localparam int              LC_W      = $clog2(LINES_PER_FRAME + 1);
  localparam logic [LC_W-1:0] LAST_LINE = LC_W'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              prio_reg, prio_next;
  logic [LC_W-1:0]   line_cnt_reg, line_cnt_next;
  logic              fsync_reg;
  logic              frame_done_reg;
  logic              frame_end;
  logic              wdog_fire;
  logic              stall_hit;

  logic [1:0]             s_valid, s_user, s_last, s_ready;
  logic [1:0]             cand, flush;
  logic [TDATA_WIDTH-1:0] s_data [2];

  logic                   sel;
  logic                   granted;
  logic [TDATA_WIDTH-1:0] m_data;
  logic                   m_user, m_last, m_valid;
  logic                   handshake;

  assign s_valid   = {s1.tvalid, s0.tvalid};
  assign s_user    = {s1.tuser,  s0.tuser};
  assign s_last    = {s1.tlast,  s0.tlast};
  assign s_data[0] = s0.tdata;
  assign s_data[1] = s1.tdata;

  // Only a start-of-frame beat may claim the output; any other beat seen while idle is debris.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign cand[gi]  = s_valid[gi] & s_user[gi];
      assign flush[gi] = s_valid[gi] & ~s_user[gi];
    end
  endgenerate

  assign sel       = (state_reg == GRANT1);
  assign granted   = (state_reg != IDLE);
  assign m_valid   = granted & s_valid[sel];
  assign m_data    = granted ? s_data[sel] : '0;
  assign m_user    = granted & s_user[sel];
  assign m_last    = granted & s_last[sel];
  assign handshake = m_valid & m.tready;

  always_comb begin
    state_next    = state_reg;
    prio_next     = prio_reg;
    line_cnt_next = line_cnt_reg;
    frame_end     = 1'b0;
    wdog_fire     = 1'b0;
    s_ready       = 2'b00;
    case (state_reg)
      IDLE: begin
        s_ready = flush;
        if (cand[0] && (!cand[1] || !prio_reg)) begin
          state_next = GRANT0;
        end else if (cand[1]) begin
          state_next = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        s_ready[sel] = m.tready;
        if (handshake && m_last) begin
          if (line_cnt_reg == LAST_LINE) begin
            state_next    = IDLE;
            line_cnt_next = '0;
            prio_next     = ~sel;
            frame_end     = 1'b1;
          end else begin
            line_cnt_next = line_cnt_reg + 1'b1;
          end
        end else if (stall_hit) begin
          state_next    = IDLE;
          line_cnt_next = '0;
          prio_next     = ~sel;
          wdog_fire     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      prio_reg       <= 1'b0;
      line_cnt_reg   <= '0;
      fsync_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prio_reg       <= prio_next;
      line_cnt_reg   <= line_cnt_next;
      fsync_reg      <= handshake & m_user;
      frame_done_reg <= frame_end;
    end
  end

`ifdef FSA_WATCHDOG_EN
  localparam int              WD_W      = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic            wdog_err_reg;

  // Counts consecutive granted cycles without an output handshake.
  assign stall_hit = granted & ~handshake & (stall_cnt_reg == WDOG_LAST);

  always_comb begin
    stall_cnt_next = stall_cnt_reg + 1'b1;
    if (!granted || handshake || stall_hit) begin
      stall_cnt_next = '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_cnt_reg <= '0;
      wdog_err_reg  <= 1'b0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      if (wdog_fire) begin
        wdog_err_reg <= 1'b1;
      end
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign stall_hit = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // Reset drops every handshake immediately so an interrupted frame is abandoned in the reset cycle.
  assign m.tdata    = areset ? '0 : m_data;
  assign m.tuser    = m_user & ~areset;
  assign m.tlast    = m_last & ~areset;
  assign m.tvalid   = m_valid & ~areset;
  assign s0.tready  = s_ready[0] & ~areset;
  assign s1.tready  = s_ready[1] & ~areset;
  assign fsync      = fsync_reg;
  assign frame_done = frame_done_reg;
  assign grant      = {state_reg == GRANT1, state_reg == GRANT0};
endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed bench for frame_stream_arbiter: 4 lines x 8 beats per frame, watchdog limit 16.
// Watchdog scenario checks differ depending on whether FSA_WATCHDOG_EN is defined.
module tb_frame_stream_arbiter;
  localparam int TW  = 32;
  localparam int LPF = 4;
  localparam int BPL = 8;
  localparam int WD  = 16;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          user;
    logic          last;
  } beat_t;

  logic       aclk = 1'b0;
  logic       areset = 1'b1;
  logic       fsync, frame_done, wdog_err;
  logic [1:0] grant;

  frame_stream_arbiter_if #(.TDATA_WIDTH(TW)) s0_if ();
  frame_stream_arbiter_if #(.TDATA_WIDTH(TW)) s1_if ();
  frame_stream_arbiter_if #(.TDATA_WIDTH(TW)) m_if ();

  frame_stream_arbiter #(
    .TDATA_WIDTH(TW), .LINES_PER_FRAME(LPF), .WDOG_CYCLES(WD)
  ) dut (
    .aclk(aclk), .areset(areset), .s0(s0_if), .s1(s1_if), .m(m_if),
    .fsync(fsync), .grant(grant), .frame_done(frame_done), .wdog_err(wdog_err)
  );

  always #5 aclk = ~aclk;

  beat_t s0_q[$], s1_q[$], exp_q[$];
  int    gaps[$];
  int    total = 0, bad = 0, cyc = 0;
  int    fsync_cnt = 0, fd_cnt = 0, flush_cnt = 0, s1r_viol = 0;
  int    g01_cnt = 0, g10_cnt = 0, m_beats = 0, last_end = -1, low_run = 0;
  bit    s0_en = 1'b0, s1_en = 1'b0, rnd_ready = 1'b0;

  logic          smp_mvalid, smp_muser, smp_mlast, smp_s0r, smp_s1r, smp_fsync, smp_fd, smp_wdog;
  logic [TW-1:0] smp_mdata;
  logic [1:0]    smp_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int src, input int fid, input int idx, input int mid_sof);
    beat_t b;
    b.data = {8'(src), 8'(fid), 8'(idx / BPL), 8'(idx % BPL)};
    b.user = (idx == 0) || (idx == mid_sof);
    b.last = ((idx % BPL) == BPL - 1);
    return b;
  endfunction

  task automatic push_src(input int src, input int fid, input int n, input int mid_sof);
    for (int i = 0; i < n; i++) begin
      if (src == 0) s0_q.push_back(mk(src, fid, i, mid_sof));
      else          s1_q.push_back(mk(src, fid, i, mid_sof));
    end
  endtask

  task automatic push_exp(input int src, input int fid, input int n, input int mid_sof);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(src, fid, i, mid_sof));
  endtask

  task automatic push_flush(input int src, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {8'(src), 8'hFF, 8'hFF, 8'(i)};
      b.user = 1'b0;
      b.last = 1'b0;
      if (src == 0) s0_q.push_back(b);
      else          s1_q.push_back(b);
    end
  endtask

  task automatic drive_srcs();
    bit r;
    s0_if.tvalid = s0_en && (s0_q.size() > 0);
    s0_if.tdata  = (s0_q.size() > 0) ? s0_q[0].data : '0;
    s0_if.tuser  = (s0_q.size() > 0) ? s0_q[0].user : 1'b0;
    s0_if.tlast  = (s0_q.size() > 0) ? s0_q[0].last : 1'b0;
    s1_if.tvalid = s1_en && (s1_q.size() > 0);
    s1_if.tdata  = (s1_q.size() > 0) ? s1_q[0].data : '0;
    s1_if.tuser  = (s1_q.size() > 0) ? s1_q[0].user : 1'b0;
    s1_if.tlast  = (s1_q.size() > 0) ? s1_q[0].last : 1'b0;
    r = 1'b1;
    if (rnd_ready) r = ($urandom_range(0, 1) == 1) || (low_run >= 4);
    low_run = r ? 0 : low_run + 1;
    m_if.tready = r;
  endtask

  // One clock: sample at the falling edge, then advance the sources after the rising edge.
  task automatic step();
    bit    s0_hs, s1_hs;
    beat_t o, e;
    @(negedge aclk);
    smp_mvalid = m_if.tvalid; smp_mdata = m_if.tdata; smp_muser = m_if.tuser;
    smp_mlast = m_if.tlast; smp_s0r = s0_if.tready; smp_s1r = s1_if.tready;
    smp_fsync = fsync; smp_fd = frame_done; smp_wdog = wdog_err; smp_grant = grant;
    s0_hs = s0_if.tvalid && s0_if.tready;
    s1_hs = s1_if.tvalid && s1_if.tready;
    if (fsync) fsync_cnt++;
    if (frame_done) fd_cnt++;
    if (grant == 2'b01) g01_cnt++;
    if (grant == 2'b10) g10_cnt++;
    if (grant == 2'b01 && s1_if.tready) s1r_viol++;
    if (grant == 2'b00 && s1_hs) flush_cnt++;
    if (m_if.tvalid && m_if.tready) begin
      o.data = m_if.tdata; o.user = m_if.tuser; o.last = m_if.tlast;
      m_beats++;
      if (o.user && o.data[15:0] == 16'h0000 && last_end >= 0) begin
        gaps.push_back(cyc - last_end);
        last_end = -1;
      end
      if (o.last && o.data[15:8] == 8'(LPF - 1)) last_end = cyc;
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL m_extra: observed=%0h expected=none", o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m_beat", 64'(o), 64'(e));
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    if (s0_hs && s0_q.size() > 0) void'(s0_q.pop_front());
    if (s1_hs && s1_q.size() > 0) void'(s1_q.pop_front());
    drive_srcs();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    areset = 1'b1; s0_en = 1'b0; s1_en = 1'b0; rnd_ready = 1'b0;
    s0_q.delete(); s1_q.delete(); exp_q.delete();
    drive_srcs();
    step();
    areset = 1'b0; s0_en = 1'b1; s1_en = 1'b1;
    drive_srcs();
    step();
    chk("rst_m_tvalid", 64'(smp_mvalid), 64'd0);
    chk("rst_m_tdata",  64'(smp_mdata),  64'd0);
    chk("rst_m_tuser",  64'(smp_muser),  64'd0);
    chk("rst_m_tlast",  64'(smp_mlast),  64'd0);
    chk("rst_s0_tready", 64'(smp_s0r),   64'd0);
    chk("rst_s1_tready", 64'(smp_s1r),   64'd0);
    chk("rst_fsync",    64'(smp_fsync),  64'd0);
    chk("rst_frame_done", 64'(smp_fd),   64'd0);
    chk("rst_grant",    64'(smp_grant),  64'd0);
    chk("rst_wdog_err", 64'(smp_wdog),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    drive_srcs();
    repeat (3) @(posedge aclk);
    #1;
    do_reset();

    // 1: single s0 frame
    fsync_cnt = 0; fd_cnt = 0; g01_cnt = 0; m_beats = 0;
    push_src(0, 1, 32, -1); push_exp(0, 1, 32, -1); drive_srcs();
    run(200); step(); step();
    chk("t1_beats", 64'(m_beats), 64'd32);
    chk("t1_fsync", 64'(fsync_cnt), 64'd1);
    chk("t1_frame_done", 64'(fd_cnt), 64'd1);
    chk("t1_grant01_cycles", 64'(g01_cnt), 64'd32);
    chk("t1_grant_after", 64'(smp_grant), 64'd0);

    // 2: simultaneous SOF, three frames each, alternating with one idle cycle
    do_reset();
    fsync_cnt = 0; fd_cnt = 0; gaps.delete(); last_end = -1;
    for (int f = 0; f < 3; f++) begin
      push_src(0, f, 32, -1); push_src(1, f, 32, -1);
      push_exp(0, f, 32, -1); push_exp(1, f, 32, -1);
    end
    drive_srcs();
    run(1000); step(); step();
    chk("t2_frame_done", 64'(fd_cnt), 64'd6);
    chk("t2_fsync", 64'(fsync_cnt), 64'd6);
    chk("t2_gap_count", 64'(gaps.size()), 64'd5);
    foreach (gaps[i]) chk("t2_gap", 64'(gaps[i]), 64'd2);

    // 3: s1 joins mid-line, flush then a frame carrying an extra mid-frame SOF
    fsync_cnt = 0; fd_cnt = 0; flush_cnt = 0; g10_cnt = 0;
    push_flush(1, 5); push_src(1, 10, 32, 16); push_exp(1, 10, 32, 16); drive_srcs();
    run(300); step(); step();
    chk("t3_flushed", 64'(flush_cnt), 64'd5);
    chk("t3_fsync_midsof", 64'(fsync_cnt), 64'd2);
    chk("t3_frame_done", 64'(fd_cnt), 64'd1);
    chk("t3_grant10_cycles", 64'(g10_cnt), 64'd32);

    // 4: random output backpressure during an s0 frame while s1 waits
    fd_cnt = 0; s1r_viol = 0; rnd_ready = 1'b1;
    push_src(0, 20, 32, -1); push_src(1, 21, 32, -1);
    push_exp(0, 20, 32, -1); push_exp(1, 21, 32, -1); drive_srcs();
    run(2000);
    rnd_ready = 1'b0; drive_srcs(); step(); step();
    chk("t4_s1_tready_stalled", 64'(s1r_viol), 64'd0);
    chk("t4_frame_done", 64'(fd_cnt), 64'd2);

    // 5: reset at beat 10 of an s1 frame, then priority restarts at s0
    push_src(0, 30, 32, -1); push_exp(0, 30, 32, -1); drive_srcs();
    run(200); step();
    push_src(1, 31, 32, -1); push_exp(1, 31, 10, -1); drive_srcs();
    run(200);
    chk("t5_s1_beat10_pending", 64'(s1_if.tdata), 64'({8'd1, 8'd31, 8'd1, 8'd2}));
    do_reset();
    fd_cnt = 0;
    push_src(0, 32, 32, -1); push_src(1, 33, 32, -1);
    push_exp(0, 32, 32, -1); push_exp(1, 33, 32, -1); drive_srcs();
    run(500); step(); step();
    chk("t5_frame_done", 64'(fd_cnt), 64'd2);

    // 6: s0 stalls after two lines while s1 waits with SOF
    fd_cnt = 0;
    push_src(0, 40, 16, -1); push_exp(0, 40, 16, -1); push_src(1, 41, 32, -1); drive_srcs();
    run(200);
`ifdef FSA_WATCHDOG_EN
    repeat (16) step();
    chk("t6_grant_held", 64'(smp_grant), 64'd1);
    chk("t6_wdog_before", 64'(smp_wdog), 64'd0);
    step();
    chk("t6_grant_revoked", 64'(smp_grant), 64'd0);
    chk("t6_wdog_err", 64'(smp_wdog), 64'd1);
    chk("t6_no_frame_done", 64'(fd_cnt), 64'd0);
    push_exp(1, 41, 32, -1);
    run(200); step(); step();
    chk("t6_wdog_sticky", 64'(smp_wdog), 64'd1);
    chk("t6_s1_frame_done", 64'(fd_cnt), 64'd1);
`else
    repeat (20) step();
    chk("t6_grant_held", 64'(smp_grant), 64'd1);
    chk("t6_wdog_err", 64'(smp_wdog), 64'd0);
    chk("t6_s1_waiting", 64'(s1_q.size()), 64'd32);
    chk("t6_no_frame_done", 64'(fd_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
